// File: rtl/bayer_line_buffer_5x5.sv
`default_nettype none
// ============================================================================
// bayer_line_buffer_5x5 : four-line Bayer RAW buffer emitting 5-row column taps
// Revision 1.0
// ============================================================================
module bayer_line_buffer_5x5 #(
    parameter int MAX_WIDTH = 2048,
    parameter int AW        = 11,
    parameter bit X_INV     = 1'b0,
    parameter bit Y_INV     = 1'b0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        I_VALID,
    input  logic        I_SOF,
    input  logic        I_EOL,
    input  logic [9:0]  I_DATA,
    output logic        O_VALID,
    output logic        O_SOF,
    output logic        O_EOL,
    output logic [9:0]  D0,
    output logic [9:0]  D1,
    output logic [9:0]  D2,
    output logic [9:0]  D3,
    output logic [9:0]  D4,
    output logic        X,
    output logic        Y,
    output logic        O_OVF
);

    localparam logic [AW-1:0] C_LAST_COL = AW'(MAX_WIDTH - 1);

    logic [AW-1:0] r_col;
    logic          r_row_par;
    logic [2:0]    r_rows_done;
    logic [1:0]    r_ptr;

    logic [AW-1:0] w_col;
    logic          w_row_par;
    logic [2:0]    w_rows_done;
    logic          w_force;
    logic          w_end;
    logic          w_accept;

    logic          r_s1_valid;
    logic          r_s1_sof;
    logic          r_s1_eol;
    logic          r_s1_ovf;
    logic          r_s1_x;
    logic          r_s1_y;
    logic [9:0]    r_s1_pix;
    logic [2:0]    r_s1_rows;
    logic [1:0]    r_s1_ptr;
    logic [9:0]    r_rd [4];

    logic [9:0]    w_t0, w_t1, w_t2, w_t3;

    // SOF takes effect on the pixel that carries it
    assign w_col       = I_SOF ? '0 : r_col;
    assign w_row_par   = I_SOF ? 1'b0 : r_row_par;
    assign w_rows_done = I_SOF ? 3'd0 : r_rows_done;
    assign w_force     = (w_col == C_LAST_COL) && !I_EOL;
    assign w_end       = I_EOL | w_force;
    assign w_accept    = I_VALID & RST_N;

    // Circular line pointer: the current line overwrites the line four rows up,
    // whose old contents are read out in the same cycle as the D0 tap.
    for (genvar k = 0; k < 4; k++) begin : g_line
        logic [9:0] mem [MAX_WIDTH];
        always_ff @(posedge CLK) begin
            if (w_accept) begin
                r_rd[k] <= mem[w_col];
                if (r_ptr == 2'(k)) begin
                    mem[w_col] <= I_DATA;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_col       <= '0;
            r_row_par   <= 1'b0;
            r_rows_done <= 3'd0;
            r_ptr       <= 2'd0;
        end else if (I_VALID) begin
            if (w_end) begin
                r_col       <= '0;
                r_row_par   <= ~w_row_par;
                r_rows_done <= (w_rows_done == 3'd4) ? 3'd4 : w_rows_done + 3'd1;
                r_ptr       <= r_ptr + 2'd1;
            end else begin
                r_col       <= w_col + AW'(1);
                r_row_par   <= w_row_par;
                r_rows_done <= w_rows_done;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1_valid <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_x     <= 1'b0;
            r_s1_y     <= 1'b0;
            r_s1_pix   <= '0;
            r_s1_rows  <= 3'd0;
            r_s1_ptr   <= 2'd0;
        end else begin
            r_s1_valid <= I_VALID;
            if (I_VALID) begin
                r_s1_sof  <= I_SOF;
                r_s1_eol  <= I_EOL;
                r_s1_ovf  <= w_force;
                r_s1_x    <= w_col[0] ^ X_INV;
                r_s1_y    <= w_row_par ^ Y_INV;
                r_s1_pix  <= I_DATA;
                r_s1_rows <= w_rows_done;
                r_s1_ptr  <= r_ptr;
            end
        end
    end

    always_comb begin
        w_t3 = (r_s1_rows >= 3'd1) ? r_rd[r_s1_ptr - 2'd1] : '0;
        w_t2 = (r_s1_rows >= 3'd2) ? r_rd[r_s1_ptr - 2'd2] : '0;
        w_t1 = (r_s1_rows >= 3'd3) ? r_rd[r_s1_ptr - 2'd3] : '0;
        w_t0 = (r_s1_rows >= 3'd4) ? r_rd[r_s1_ptr]        : '0;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            O_VALID <= 1'b0;
            O_SOF   <= 1'b0;
            O_EOL   <= 1'b0;
            O_OVF   <= 1'b0;
            X       <= 1'b0;
            Y       <= 1'b0;
            D0      <= '0;
            D1      <= '0;
            D2      <= '0;
            D3      <= '0;
            D4      <= '0;
        end else begin
            O_VALID <= r_s1_valid;
            O_SOF   <= r_s1_valid & r_s1_sof;
            O_EOL   <= r_s1_valid & r_s1_eol;
            if (r_s1_valid) begin
                D0 <= w_t0;
                D1 <= w_t1;
                D2 <= w_t2;
                D3 <= w_t3;
                D4 <= r_s1_pix;
                X  <= r_s1_x;
                Y  <= r_s1_y;
                if (r_s1_sof) begin
                    O_OVF <= r_s1_ovf;
                end else if (r_s1_ovf) begin
                    O_OVF <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bayer_line_buffer_5x5.sv
`default_nettype none
// ============================================================================
// tb_bayer_line_buffer_5x5 : scoreboard bench against a frame-array model
// Revision 1.0
// ============================================================================
module tb_bayer_line_buffer_5x5;

    localparam int MW  = 16;
    localparam int AWB = 4;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       I_VALID = 1'b0;
    logic       I_SOF = 1'b0;
    logic       I_EOL = 1'b0;
    logic [9:0] I_DATA = '0;

    logic       o_valid, o_sof, o_eol, o_x, o_y, o_ovf;
    logic [9:0] d0, d1, d2, d3, d4;
    logic       n_valid, n_sof, n_eol, n_x, n_y, n_ovf;
    logic [9:0] n0, n1, n2, n3, n4;

    bayer_line_buffer_5x5 #(.MAX_WIDTH(MW), .AW(AWB), .X_INV(1'b0), .Y_INV(1'b0)) dut (
        .CLK(CLK), .RST_N(RST_N), .I_VALID(I_VALID), .I_SOF(I_SOF), .I_EOL(I_EOL),
        .I_DATA(I_DATA), .O_VALID(o_valid), .O_SOF(o_sof), .O_EOL(o_eol),
        .D0(d0), .D1(d1), .D2(d2), .D3(d3), .D4(d4), .X(o_x), .Y(o_y), .O_OVF(o_ovf)
    );

    bayer_line_buffer_5x5 #(.MAX_WIDTH(MW), .AW(AWB), .X_INV(1'b1), .Y_INV(1'b1)) dut_inv (
        .CLK(CLK), .RST_N(RST_N), .I_VALID(I_VALID), .I_SOF(I_SOF), .I_EOL(I_EOL),
        .I_DATA(I_DATA), .O_VALID(n_valid), .O_SOF(n_sof), .O_EOL(n_eol),
        .D0(n0), .D1(n1), .D2(n2), .D3(n3), .D4(n4), .X(n_x), .Y(n_y), .O_OVF(n_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int d0, d1, d2, d3, d4;
        int x, y, sof, eol, ovf, issue;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    exp_t last_e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    // reference model: whole-frame picture indexed by (row, col)
    int pix [64][MW];
    int m_row = 0;
    int m_col = 0;
    int m_ovf = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic send(input int data, input bit sof, input bit eol);
        exp_t e;
        int   r, c;
        bit   frc;
        if (sof) begin
            m_row = 0;
            m_col = 0;
            m_ovf = 0;
        end
        r = m_row;
        c = m_col;
        pix[r][c] = data;
        e.d4 = data;
        e.d3 = (r >= 1) ? pix[r-1][c] : 0;
        e.d2 = (r >= 2) ? pix[r-2][c] : 0;
        e.d1 = (r >= 3) ? pix[r-3][c] : 0;
        e.d0 = (r >= 4) ? pix[r-4][c] : 0;
        frc = (c == MW - 1) && !eol;
        if (frc) m_ovf = 1;
        e.x   = c % 2;
        e.y   = r % 2;
        e.sof = int'(sof);
        e.eol = int'(eol);
        e.ovf = m_ovf;
        @(posedge CLK);
        #1;
        I_VALID = 1'b1;
        I_SOF   = sof;
        I_EOL   = eol;
        I_DATA  = 10'(data);
        e.issue = cyc;
        q.push_back(e);
        if (eol || frc) begin
            m_col = 0;
            m_row = m_row + 1;
        end else begin
            m_col = m_col + 1;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            I_VALID = 1'b0;
            I_SOF   = 1'b0;
            I_EOL   = 1'b0;
            I_DATA  = 10'($urandom);
        end
    endtask

    task automatic rand_frame(input int w, input int nrows, input int gapmax);
        for (int r = 0; r < nrows; r++) begin
            for (int c = 0; c < w; c++) begin
                send(int'($urandom_range(0, 1023)), (r == 0) && (c == 0), c == w - 1);
            end
            if (r == 1) idle(5);
            else if (gapmax > 0) idle(int'($urandom_range(0, gapmax)));
        end
    endtask

    always @(negedge CLK) begin
        if (!RST_N) begin
            if (cyc >= 1) begin
                chk("reset_valid", int'(o_valid), 0);
                chk("reset_taps", int'({d0, d1, d2, d3, d4}), 0);
                chk("reset_ovf", int'(o_ovf), 0);
            end
            last_e = '{default: 0};
        end else if (o_valid) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got 1, expected 0 (cycle %0d)", cyc);
            end else begin
                mon_e = q.pop_front();
                chk("latency", cyc - mon_e.issue, 2);
                chk("D0", int'(d0), mon_e.d0);
                chk("D1", int'(d1), mon_e.d1);
                chk("D2", int'(d2), mon_e.d2);
                chk("D3", int'(d3), mon_e.d3);
                chk("D4", int'(d4), mon_e.d4);
                chk("X", int'(o_x), mon_e.x);
                chk("Y", int'(o_y), mon_e.y);
                chk("O_SOF", int'(o_sof), mon_e.sof);
                chk("O_EOL", int'(o_eol), mon_e.eol);
                chk("O_OVF", int'(o_ovf), mon_e.ovf);
                chk("inv_valid", int'(n_valid), 1);
                chk("inv_X", int'(n_x), mon_e.x ^ 1);
                chk("inv_Y", int'(n_y), mon_e.y ^ 1);
                chk("inv_D2", int'(n2), mon_e.d2);
                last_e = mon_e;
            end
        end else begin
            chk("hold_taps", int'({d0, d1, d2, d3, d4}),
                int'({10'(last_e.d0), 10'(last_e.d1), 10'(last_e.d2), 10'(last_e.d3), 10'(last_e.d4)}));
            chk("hold_X", int'(o_x), last_e.x);
            chk("hold_Y", int'(o_y), last_e.y);
            chk("idle_sof", int'(o_sof), 0);
            chk("inv_idle_valid", int'(n_valid), 0);
        end
    end

    initial begin
        RST_N   = 1'b0;
        I_VALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            I_DATA = 10'($urandom);
            @(posedge CLK);
        end
        #1;
        RST_N   = 1'b1;
        I_VALID = 1'b0;

        // pixels before any SOF start at column 0, row 0
        for (int c = 0; c < 3; c++) send(int'($urandom_range(0, 1023)), 1'b0, c == 2);
        idle(2);

        // 8x6 ramp frame, gapless
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                send(16 * r + c, (r == 0) && (c == 0), c == 7);
            end
        end

        // back-to-back random frames, with inter-line gaps
        rand_frame(int'($urandom_range(2, 16)), 7, 0);
        rand_frame(int'($urandom_range(1, 16)), 6, 3);
        rand_frame(MW, 5, 2);

        // one-pixel lines: SOF and EOL on the same pixel
        send(int'($urandom_range(0, 1023)), 1'b1, 1'b1);
        for (int r = 1; r < 6; r++) send(int'($urandom_range(0, 1023)), 1'b0, 1'b1);
        idle(3);

        // overflow: 20 pixels without EOL
        for (int i = 0; i < 20; i++) send(100 + i, i == 0, 1'b0);
        idle(4);

        // next SOF clears the overflow flag
        rand_frame(5, 6, 2);

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
        idle(2);
        chk("drain", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
